// File: rtl/move_merge_if.sv
`default_nettype none
// ============================================================================
// move_merge_if : request/result bundle between the move decoder, the
//                 move/merge engine and the board register.
// Rev 1.0
// ============================================================================
interface move_merge_if #(
   parameter int N  = 4,
   parameter int TW = 12,
   parameter int SW = 20
);
   localparam int MW = $clog2(N*N/2+1);

   logic                start;
   logic [3:0]          dir;
   logic [N*N*TW-1:0]   board;
   logic                ready;
   logic                done;
   logic [N*N*TW-1:0]   result;
   logic [SW-1:0]       score;
   logic [MW-1:0]       merge_cnt;
   logic                moved;
   logic                err;

   modport master (
      output start, dir, board,
      input  ready, done, result, score, merge_cnt, moved, err
   );

   modport slave (
      input  start, dir, board,
      output ready, done, result, score, merge_cnt, moved, err
   );
endinterface
`default_nettype wire

// File: rtl/move_merge_engine.sv
`default_nettype none
// ============================================================================
// move_merge_engine : sequential 2048 move/merge, one board line per cycle.
// Rev 1.0
// ============================================================================
module move_merge_engine #(
   parameter int N  = 4,
   parameter int TW = 12,
   parameter int SW = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   move_merge_if.slave bus
);
   localparam int MW = $clog2(N*N/2+1);
   localparam int LW = $clog2(N);
   localparam int AW = ((SW > TW) ? SW : TW) + $clog2(N) + 2;
   localparam logic [AW-1:0] SCORE_MAX = {{(AW-SW){1'b0}}, {SW{1'b1}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PROC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state;
   logic [N*N*TW-1:0]   work;
   logic [3:0]          dir_q;
   logic [LW-1:0]       line;
   logic [SW-1:0]       score_acc;
   logic [MW-1:0]       merge_acc;
   logic                moved_acc;

   logic [N*N*TW-1:0]   result_q;
   logic [SW-1:0]       score_q;
   logic [MW-1:0]       merge_q;
   logic                moved_q;
   logic                err_q;

   logic [TW-1:0]       e_in  [N];
   logic [TW-1:0]       e_mid [N];
   logic [TW-1:0]       e_mrg [N];
   logic [TW-1:0]       e_out [N];
   logic [AW-1:0]       line_score;
   logic [AW-1:0]       score_sum;
   logic [MW-1:0]       line_merges;
   logic                line_moved;
   logic [N*N*TW-1:0]   next_work;
   logic [SW-1:0]       score_next;
   logic [MW-1:0]       merge_next;
   logic                dir_ok;

   // Element k of line l, k=0 being the edge tiles slide toward.
   function automatic int tile_index(input logic [3:0] d, input int l, input int k);
      case (d)
         4'b0001: tile_index = k*N + l;
         4'b0010: tile_index = (N-1-k)*N + l;
         4'b1000: tile_index = l*N + (N-1-k);
         default: tile_index = l*N + k;
      endcase
   endfunction

   assign dir_ok = (bus.dir == 4'b0001) || (bus.dir == 4'b0010) ||
                   (bus.dir == 4'b0100) || (bus.dir == 4'b1000);

   always_comb begin
      logic [LW:0] j;
      line_score  = '0;
      line_merges = '0;
      line_moved  = 1'b0;
      next_work   = work;
      for (int k = 0; k < N; k++) begin
         e_in[k]  = work[tile_index(dir_q, int'(line), k)*TW +: TW];
         e_mid[k] = '0;
         e_out[k] = '0;
      end
      j = '0;
      for (int k = 0; k < N; k++) begin
         if (e_in[k] != '0) begin
            e_mid[j[LW-1:0]] = e_in[k];
            j = j + (LW+1)'(1);
         end
      end
      for (int k = 0; k < N; k++) e_mrg[k] = e_mid[k];
      // A set MSB means doubling would overflow the tile width: leave the pair alone.
      for (int k = 0; k < N-1; k++) begin
         if (e_mrg[k] != '0 && e_mrg[k] == e_mrg[k+1] && !e_mrg[k][TW-1]) begin
            e_mrg[k]    = {e_mrg[k][TW-2:0], 1'b0};
            e_mrg[k+1]  = '0;
            line_score  = line_score + AW'(e_mrg[k]);
            line_merges = line_merges + MW'(1);
         end
      end
      j = '0;
      for (int k = 0; k < N; k++) begin
         if (e_mrg[k] != '0) begin
            e_out[j[LW-1:0]] = e_mrg[k];
            j = j + (LW+1)'(1);
         end
      end
      for (int k = 0; k < N; k++) begin
         if (e_out[k] != e_in[k]) line_moved = 1'b1;
         next_work[tile_index(dir_q, int'(line), k)*TW +: TW] = e_out[k];
      end
      score_sum  = {{(AW-SW){1'b0}}, score_acc} + line_score;
      score_next = (score_sum > SCORE_MAX) ? {SW{1'b1}} : score_sum[SW-1:0];
      merge_next = merge_acc + line_merges;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         work      <= '0;
         dir_q     <= '0;
         line      <= '0;
         score_acc <= '0;
         merge_acc <= '0;
         moved_acc <= 1'b0;
         result_q  <= '0;
         score_q   <= '0;
         merge_q   <= '0;
         moved_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  work      <= bus.board;
                  dir_q     <= bus.dir;
                  line      <= '0;
                  score_acc <= '0;
                  merge_acc <= '0;
                  moved_acc <= 1'b0;
                  if (dir_ok) begin
                     state <= S_PROC;
                  end else begin
                     state    <= S_DONE;
                     result_q <= bus.board;
                     score_q  <= '0;
                     merge_q  <= '0;
                     moved_q  <= 1'b0;
                     err_q    <= 1'b1;
                  end
               end
            end
            S_PROC: begin
               work      <= next_work;
               score_acc <= score_next;
               merge_acc <= merge_next;
               moved_acc <= moved_acc | line_moved;
               line      <= line + LW'(1);
               if (line == LW'(N-1)) begin
                  state    <= S_DONE;
                  result_q <= next_work;
                  score_q  <= score_next;
                  merge_q  <= merge_next;
                  moved_q  <= moved_acc | line_moved;
                  err_q    <= 1'b0;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.ready     = (state == S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.result    = result_q;
   assign bus.score     = score_q;
   assign bus.merge_cnt = merge_q;
   assign bus.moved     = moved_q;
   assign bus.err       = err_q;
endmodule
`default_nettype wire
